// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared states, encodings and per-state control word for the multicycle MIPS control unit
// Optional feature: MIPS_ADDI_EN adds the ADDI_EXEC/ADDI_WB states.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_RD    = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_EXEC      = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9
`ifdef MIPS_ADDI_EN
        ,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
`endif
    } state_e;

    typedef enum logic [1:0] {
        ALU_OP_NONE  = 2'd0,
        ALU_OP_ADD   = 2'd1,
        ALU_OP_SUB   = 2'd2,
        ALU_OP_FUNCT = 2'd3
    } alu_op_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef MIPS_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] SRC_B_REG     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // pc_cond marks the branch state, where pc_en follows the ALU zero flag.
    typedef struct packed {
        logic       pc_en;
        logic       pc_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        alu_op_e    alu_op;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(input state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_b = SRC_B_FOUR;
                c.alu_op    = ALU_OP_ADD;
                c.pc_en     = 1'b1;
                c.pc_source = PC_SRC_ALU;
            end
            S_DECODE: begin
                c.alu_src_b = SRC_B_IMM_SH2;
                c.alu_op    = ALU_OP_ADD;
            end
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_IMM;
                c.alu_op    = ALU_OP_ADD;
            end
            S_MEM_RD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_REG;
                c.alu_op    = ALU_OP_FUNCT;
            end
            S_R_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_REG;
                c.alu_op    = ALU_OP_SUB;
                c.pc_source = PC_SRC_ALUOUT;
                c.pc_cond   = 1'b1;
            end
            S_JUMP: begin
                c.pc_en     = 1'b1;
                c.pc_source = PC_SRC_JUMP;
            end
`ifdef MIPS_ADDI_EN
            S_ADDI_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_IMM;
                c.alu_op    = ALU_OP_ADD;
            end
            S_ADDI_WB: begin
                c.reg_write = 1'b1;
            end
`endif
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps the FSM's ALUOp class plus funct to the 4-bit ALU operation code
module alu_decoder
    import mips_pkg::*;
(
    input  alu_op_e    alu_op_i,
    input  logic [5:0] funct_i,
    output logic [3:0] alu_control_o,
    output logic       funct_valid_o
);

    always_comb begin
        alu_control_o = ALU_AND;
        funct_valid_o = 1'b1;
        case (alu_op_i)
            ALU_OP_ADD: alu_control_o = ALU_ADD;
            ALU_OP_SUB: alu_control_o = ALU_SUB;
            ALU_OP_FUNCT: begin
                case (funct_i)
                    FN_ADD: alu_control_o = ALU_ADD;
                    FN_SUB: alu_control_o = ALU_SUB;
                    FN_AND: alu_control_o = ALU_AND;
                    FN_OR:  alu_control_o = ALU_OR;
                    FN_SLT: alu_control_o = ALU_SLT;
                    default: begin
                        alu_control_o = ALU_ADD;
                        funct_valid_o = 1'b0;
                    end
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - Moore control FSM for the multicycle MIPS datapath (MIPS_ADDI_EN enables addi)
module mips_multicycle_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_en,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [3:0] alu_control,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_e state_q, state_d;
    ctrl_t  ctrl_q;
    ctrl_t  ctrl_c;
    logic   is_lw_q;
    logic   illegal_d;
    logic   funct_valid;

    alu_decoder u_alu_decoder (
        .alu_op_i      (ctrl_c.alu_op),
        .funct_i       (funct),
        .alu_control_o (alu_control),
        .funct_valid_o (funct_valid)
    );

    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MIPS_ADDI_EN
                    OP_ADDI:      state_d = S_ADDI_EXEC;
`endif
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: state_d = is_lw_q ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = S_MEM_WB;
            S_EXEC: begin
                state_d   = funct_valid ? S_R_WB : S_FETCH;
                illegal_d = ~funct_valid;
            end
`ifdef MIPS_ADDI_EN
            S_ADDI_EXEC: state_d = S_ADDI_WB;
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // The control word for the next state is registered, so outputs come straight off flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            ctrl_q  <= state_ctrl(S_FETCH);
            is_lw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= state_ctrl(state_d);
            if (state_q == S_DECODE) begin
                is_lw_q <= (opcode == OP_LW);
            end
        end
    end

    // While reset is held, present FETCH selects but suppress every write/strobe.
    always_comb begin
        ctrl_c = ctrl_q;
        if (reset) begin
            ctrl_c           = state_ctrl(S_FETCH);
            ctrl_c.pc_en     = 1'b0;
            ctrl_c.pc_cond   = 1'b0;
            ctrl_c.ir_write  = 1'b0;
            ctrl_c.mem_read  = 1'b0;
            ctrl_c.mem_write = 1'b0;
            ctrl_c.reg_write = 1'b0;
        end
    end

    assign pc_en      = ctrl_c.pc_en | (ctrl_c.pc_cond & zero);
    assign i_or_d     = ctrl_c.i_or_d;
    assign mem_read   = ctrl_c.mem_read;
    assign mem_write  = ctrl_c.mem_write;
    assign ir_write   = ctrl_c.ir_write;
    assign reg_dst    = ctrl_c.reg_dst;
    assign mem_to_reg = ctrl_c.mem_to_reg;
    assign reg_write  = ctrl_c.reg_write;
    assign alu_src_a  = ctrl_c.alu_src_a;
    assign alu_src_b  = ctrl_c.alu_src_b;
    assign pc_source  = ctrl_c.pc_source;
    assign illegal_op = illegal_d & ~reset;
    assign state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb/tb_mips_multicycle_control.sv - scoreboard bench for mips_multicycle_control (honours MIPS_ADDI_EN)
module tb_mips_multicycle_control;
    import mips_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_source;
    logic [3:0] alu_control, state;
    logic       illegal_op;

    mips_multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_en(pc_en), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
        .alu_control(alu_control), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [21:0] w;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // {state, pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
    //  alu_src_a, alu_src_b, pc_source, alu_control, illegal_op}
    function automatic logic [21:0] exw(input logic [3:0] st, input logic [3:0] ac, input logic ill, input logic z);
        logic pe = 0, iod = 0, mr = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, sa = 0;
        logic [1:0] sb = 0, ps = 0;
        logic [3:0] alc = 4'b0000;
        case (st)
            4'd0:  begin mr = 1; irw = 1; sb = 2'b01; alc = 4'b0010; pe = 1; end
            4'd1:  begin sb = 2'b11; alc = 4'b0010; end
            4'd2:  begin sa = 1; sb = 2'b10; alc = 4'b0010; end
            4'd3:  begin mr = 1; iod = 1; end
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin mw = 1; iod = 1; end
            4'd6:  begin sa = 1; alc = ac; end
            4'd7:  begin rw = 1; rd = 1; end
            4'd8:  begin sa = 1; alc = 4'b0110; ps = 2'b01; pe = z; end
            4'd9:  begin pe = 1; ps = 2'b10; end
            4'd10: begin sa = 1; sb = 2'b10; alc = 4'b0010; end
            4'd11: begin rw = 1; end
            default: ;
        endcase
        return {st, pe, iod, mr, mw, irw, rd, m2r, rw, sa, sb, ps, alc, ill};
    endfunction

    function automatic logic [21:0] rstw(input logic [3:0] st);
        return {st, 9'b0, 2'b01, 2'b00, 4'b0010, 1'b0};
    endfunction

    task automatic cyc(input logic rst, input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic [21:0] e, input string nm);
        exp_t x;
        @(posedge clk);
        #1;
        reset = rst; opcode = op; funct = fn; zero = z;
        x.w = e; x.nm = nm;
        q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t x;
            logic [21:0] got;
            x = q.pop_front();
            got = {state, pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                   alu_src_a, alu_src_b, pc_source, alu_control, illegal_op};
            n_vec++;
            if (got !== x.w) begin
                n_err++;
                $display("FAIL %s: got %06h expected %06h", x.nm, got, x.w);
            end
        end
    end

    localparam logic [5:0] FN_TAB [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    localparam logic [3:0] AC_TAB [5] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111};

    initial begin
        for (int i = 0; i < 3; i++) cyc(1, 6'd0, 6'd0, 0, rstw(4'd0), "reset_hold");

        cyc(0, 6'b100011, 6'd0, 0, exw(4'd0, 0, 0, 0), "lw_fetch");
        cyc(0, 6'b100011, 6'd0, 0, exw(4'd1, 0, 0, 0), "lw_decode");
        cyc(0, 6'b100011, 6'd0, 0, exw(4'd2, 0, 0, 0), "lw_mem_addr");
        cyc(0, 6'b100011, 6'd0, 0, exw(4'd3, 0, 0, 0), "lw_mem_rd");
        cyc(0, 6'b100011, 6'd0, 0, exw(4'd4, 0, 0, 0), "lw_mem_wb");

        cyc(0, 6'b101011, 6'd0, 0, exw(4'd0, 0, 0, 0), "sw_fetch");
        cyc(0, 6'b101011, 6'd0, 0, exw(4'd1, 0, 0, 0), "sw_decode");
        cyc(0, 6'b101011, 6'd0, 0, exw(4'd2, 0, 0, 0), "sw_mem_addr");
        cyc(0, 6'b101011, 6'd0, 0, exw(4'd5, 0, 0, 0), "sw_mem_wr");

        for (int i = 0; i < 5; i++) begin
            cyc(0, 6'b000000, FN_TAB[i], 0, exw(4'd0, 0, 0, 0), "r_fetch");
            cyc(0, 6'b000000, FN_TAB[i], 0, exw(4'd1, 0, 0, 0), "r_decode");
            cyc(0, 6'b000000, FN_TAB[i], 0, exw(4'd6, AC_TAB[i], 0, 0), "r_exec");
            cyc(0, 6'b000000, FN_TAB[i], 0, exw(4'd7, 0, 0, 0), "r_wb");
        end

        cyc(0, 6'b000100, 6'd0, 1, exw(4'd0, 0, 0, 0), "beq1_fetch");
        cyc(0, 6'b000100, 6'd0, 1, exw(4'd1, 0, 0, 0), "beq1_decode");
        cyc(0, 6'b000100, 6'd0, 1, exw(4'd8, 0, 0, 1), "beq_taken");
        cyc(0, 6'b000100, 6'd0, 0, exw(4'd0, 0, 0, 0), "beq0_fetch");
        cyc(0, 6'b000100, 6'd0, 0, exw(4'd1, 0, 0, 0), "beq0_decode");
        cyc(0, 6'b000100, 6'd0, 0, exw(4'd8, 0, 0, 0), "beq_not_taken");

        cyc(0, 6'b000010, 6'd0, 0, exw(4'd0, 0, 0, 0), "j_fetch");
        cyc(0, 6'b000010, 6'd0, 0, exw(4'd1, 0, 0, 0), "j_decode");
        cyc(0, 6'b000010, 6'd0, 0, exw(4'd9, 0, 0, 0), "j_jump");

        cyc(0, 6'b111111, 6'd0, 0, exw(4'd0, 0, 0, 0), "ill_op_fetch");
        cyc(0, 6'b111111, 6'd0, 0, exw(4'd1, 0, 1, 0), "ill_op_decode");

        cyc(0, 6'b000000, 6'b000111, 0, exw(4'd0, 0, 0, 0), "ill_fn_fetch");
        cyc(0, 6'b000000, 6'b000111, 0, exw(4'd1, 0, 0, 0), "ill_fn_decode");
        cyc(0, 6'b000000, 6'b000111, 0, exw(4'd6, 4'b0010, 1, 0), "ill_fn_exec");

        cyc(0, 6'b001000, 6'd0, 0, exw(4'd0, 0, 0, 0), "addi_fetch");
`ifdef MIPS_ADDI_EN
        cyc(0, 6'b001000, 6'd0, 0, exw(4'd1, 0, 0, 0), "addi_decode");
        cyc(0, 6'b001000, 6'd0, 0, exw(4'd10, 0, 0, 0), "addi_exec");
        cyc(0, 6'b001000, 6'd0, 0, exw(4'd11, 0, 0, 0), "addi_wb");
`else
        cyc(0, 6'b001000, 6'd0, 0, exw(4'd1, 0, 1, 0), "addi_illegal");
`endif

        cyc(0, 6'b000000, 6'b100000, 0, exw(4'd0, 0, 0, 0), "rst_r_fetch");
        cyc(0, 6'b000000, 6'b100000, 0, exw(4'd1, 0, 0, 0), "rst_r_decode");
        cyc(0, 6'b000000, 6'b100000, 0, exw(4'd6, 4'b0010, 0, 0), "rst_r_exec");
        cyc(1, 6'b000000, 6'b100000, 0, rstw(4'd7), "rst_in_r_wb");
        cyc(1, 6'b000000, 6'b100000, 0, rstw(4'd0), "rst_hold2");
        cyc(1, 6'b000000, 6'b100000, 0, rstw(4'd0), "rst_hold3");
        cyc(0, 6'b000000, 6'b100000, 0, exw(4'd0, 0, 0, 0), "post_rst_fetch");
        cyc(0, 6'b000000, 6'b100000, 0, exw(4'd1, 0, 0, 0), "post_rst_decode");

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
